rsa_modexp_ctrl: RTL

Sequencer for the RSA peripheral's modular-exponentiation datapath. It computes `acc = base^e mod n` using left-to-right binary exponentiation over a shared Montgomery multiplier. It drives the two operand-select muxes (`sel` encoding: 00 = input a, 01 = input b, 10 = constant one, 11 = zero), the multiplier start/done handshake and the accumulator/base write strobes. The host preloads the base, R²-mod-n and modulus registers before pulsing `start_i`.

---
 rtl/rsa_modexp_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_ctrl.sv
// Sequencer for left-to-right binary modular exponentiation over a shared Montgomery multiplier.
// Each operation runs issue -> wait -> writeback. All outputs are registered from the next-state values.
module rsa_modexp_ctrl #(
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    input  logic                 mul_done_i,
    output logic                 mul_start_o,
    output logic [1:0]           op_a_sel_o,
    output logic [1:0]           op_b_sel_o,
    output logic                 wr_acc_o,
    output logic                 wr_base_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CW = (EXP_WIDTH > 2) ? $clog2(EXP_WIDTH) : 1;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE_X = 3'd1,
        PRE_A = 3'd2,
        SQ    = 3'd3,
        MUL   = 3'd4,
        POST  = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_WAIT  = 2'd1,
        PH_WB    = 2'd2
    } phase_t;

    // Handshake: mul_start_o is a one-cycle launch; mul_done_i is honoured only
    // in the wait phase, and the matching write strobe follows one cycle later.
    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;

    logic       mul_start_d;
    logic [1:0] op_a_sel_d;
    logic [1:0] op_b_sel_d;
    logic       wr_acc_d;
    logic       wr_base_d;
    logic       busy_d;
    logic       done_d;
    logic       last_bit;
    logic       is_op_d;

    assign last_bit = (cnt_q == '0);

    // Next-state, phase and exponent bookkeeping
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                phase_d = PH_ISSUE;
                if (start_i) begin
                    state_d = PRE_X;
                    exp_d   = exp_i;
                    cnt_d   = CW'(EXP_WIDTH - 1);
                end
            end
            DONE: begin
                state_d = IDLE;
                phase_d = PH_ISSUE;
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: phase_d = PH_WAIT;
                    PH_WAIT: begin
                        if (mul_done_i) begin
                            phase_d = PH_WB;
                        end
                    end
                    default: begin
                        phase_d = PH_ISSUE;
                        case (state_q)
                            PRE_X: state_d = PRE_A;
                            PRE_A: state_d = SQ;
                            SQ: begin
                                // A set bit keeps the bit in place until its MUL completes.
                                if (exp_q[EXP_WIDTH-1]) begin
                                    state_d = MUL;
                                end else if (last_bit) begin
                                    state_d = POST;
                                end else begin
                                    state_d = SQ;
                                    exp_d   = {exp_q[EXP_WIDTH-2:0], 1'b0};
                                    cnt_d   = cnt_q - 1'b1;
                                end
                            end
                            MUL: begin
                                if (last_bit) begin
                                    state_d = POST;
                                end else begin
                                    state_d = SQ;
                                    exp_d   = {exp_q[EXP_WIDTH-2:0], 1'b0};
                                    cnt_d   = cnt_q - 1'b1;
                                end
                            end
                            default: state_d = DONE;
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state/phase
    always_comb begin
        is_op_d     = (state_d != IDLE) && (state_d != DONE);
        mul_start_d = is_op_d && (phase_d == PH_ISSUE);
        wr_base_d   = (state_d == PRE_X) && (phase_d == PH_WB);
        wr_acc_d    = is_op_d && (state_d != PRE_X) && (phase_d == PH_WB);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        op_a_sel_d  = SEL_ZERO;
        op_b_sel_d  = SEL_ZERO;
        case (state_d)
            PRE_X: begin
                op_a_sel_d = SEL_B;
                op_b_sel_d = SEL_B;
            end
            PRE_A: begin
                op_a_sel_d = SEL_ONE;
                op_b_sel_d = SEL_B;
            end
            SQ: begin
                op_a_sel_d = SEL_A;
                op_b_sel_d = SEL_A;
            end
            MUL: begin
                op_a_sel_d = SEL_B;
                op_b_sel_d = SEL_A;
            end
            POST: begin
                op_a_sel_d = SEL_ONE;
                op_b_sel_d = SEL_A;
            end
            default: begin
                op_a_sel_d = SEL_ZERO;
                op_b_sel_d = SEL_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= PH_ISSUE;
            cnt_q       <= '0;
            exp_q       <= '0;
            mul_start_o <= 1'b0;
            op_a_sel_o  <= SEL_ZERO;
            op_b_sel_o  <= SEL_ZERO;
            wr_acc_o    <= 1'b0;
            wr_base_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            mul_start_o <= mul_start_d;
            op_a_sel_o  <= op_a_sel_d;
            op_b_sel_o  <= op_b_sel_d;
            wr_acc_o    <= wr_acc_d;
            wr_base_o   <= wr_base_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

endmodule
